// File: rtl/tgl_dec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tgl_dec_pkg                                           |
// | Purpose  : Shared types and constants for the toggle event       |
// |            decoder (output slot state, synchronizer minimum).    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package tgl_dec_pkg;

  // Fewer than two flops does not give a metastability-safe sample.
  localparam int MIN_SYNC_STAGES = 2;

  // Output slot: EMPTY means cnt_valid=0, FULL means a count is on offer.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/tgl_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tgl_sync                                              |
// | Purpose  : Brings the asynchronous toggle line into the clk      |
// |            domain through a flop chain, optionally followed by a |
// |            two-sample glitch filter.                             |
// | Macro    : TGL_DEC_GLITCH_FILTER_EN enables the glitch filter.   |
// | Ports    : clk, reset (async, active low)                        |
// |            din     - raw toggle line                             |
// |            level   - synchronized (and filtered) level           |
// |            settled - high once level reflects real samples of    |
// |                      din taken after reset release               |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tgl_sync
  import tgl_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic settled
);

  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

`ifdef TGL_DEC_GLITCH_FILTER_EN
  localparam int FILL_W = STAGES + 1;

  logic filt;

  // The last two chain stages are consecutive samples of the synchronizer
  // output; only follow it when both agree, so one-cycle glitches die here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 1'b0;
    end else if (chain[STAGES-1] == chain[STAGES-2]) begin
      filt <= chain[STAGES-1];
    end
  end

  assign level = filt;
`else
  localparam int FILL_W = STAGES;

  assign level = chain[STAGES-1];
`endif

  // Shift register of ones marking how far real samples have travelled
  // down the chain since reset release.
  logic [FILL_W-1:0] fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else begin
      fill <= {fill[FILL_W-2:0], 1'b1};
    end
  end

  assign settled = fill[FILL_W-1];

endmodule
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : toggle_event_decoder                                  |
// | Purpose  : Receive end of a toggle-signalling link. Detects each |
// |            level change of tgl_in, accumulates events and offers |
// |            nonzero counts over a valid/ready interface.          |
// | Macro    : TGL_DEC_GLITCH_FILTER_EN (glitch filter in tgl_sync). |
// | Ports    : clk, reset (async, active low)                        |
// |            tgl_in    - remote toggle line (asynchronous)         |
// |            ovf_clr   - clears the sticky overflow flag           |
// |            cnt_ready - consumer accepts cnt_data                 |
// |            cnt_valid - cnt_data holds a nonzero count            |
// |            cnt_data  - number of events posted                   |
// |            evt_pulse - one-cycle pulse per toggle                |
// |            level_q   - decoded level of tgl_in                   |
// |            overflow  - sticky: an event was lost to saturation   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module toggle_event_decoder
  import tgl_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgl_in,
  input  logic             ovf_clr,
  input  logic             cnt_ready,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data,
  output logic             evt_pulse,
  output logic             level_q,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             settled;
  logic             primed;
  logic             last_level;
  slot_state_t      state;
  slot_state_t      state_nx;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nx;
  logic [CNT_W-1:0] data_nx;
  logic [CNT_W-1:0] pending;
  logic             ovf_nx;
  logic             free;

  tgl_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .din     (tgl_in),
    .level   (level_q),
    .settled (settled)
  );

  // Edge detect. primed lags settled by one cycle so that the first real
  // level is loaded into last_level as the baseline without a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      primed     <= 1'b0;
      last_level <= 1'b0;
      evt_pulse  <= 1'b0;
    end else begin
      primed     <= settled;
      last_level <= level_q;
      evt_pulse  <= primed & (level_q ^ last_level);
    end
  end

  // Slot state, accumulator, posted count and overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      acc      <= '0;
      cnt_data <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      cnt_data <= data_nx;
      overflow <= ovf_nx;
    end
  end

  always_comb begin
    pending  = (acc == CNT_MAX) ? CNT_MAX : acc + CNT_W'(evt_pulse);
    free     = (state == EMPTY) || cnt_ready;
    state_nx = state;
    acc_nx   = acc;
    data_nx  = cnt_data;
    ovf_nx   = overflow & ~ovf_clr;

    if (free) begin
      // The current event rides along with the newly loaded count.
      acc_nx = '0;
      if (pending != '0) begin
        data_nx  = pending;
        state_nx = FULL;
      end else begin
        state_nx = EMPTY;
      end
    end else begin
      acc_nx = pending;
      // Set has priority over a coincident clear.
      if ((acc == CNT_MAX) && evt_pulse) begin
        ovf_nx = 1'b1;
      end
    end
  end

  assign cnt_valid = (state == FULL);

endmodule
`default_nettype wire

// File: tb/tb_toggle_event_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_toggle_event_decoder                               |
// | Purpose  : Self-checking bench for toggle_event_decoder with a   |
// |            sample-history reference model and random stimulus.   |
// | Macro    : TGL_DEC_GLITCH_FILTER_EN selects filtered behaviour.  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_toggle_event_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int MAXV        = (1 << CNT_W) - 1;
`ifdef TGL_DEC_GLITCH_FILTER_EN
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int GLITCH_EVTS = 0;
`else
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int GLITCH_EVTS = 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tgl_in = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             cnt_ready = 1'b0;
  logic             cnt_valid;
  logic [CNT_W-1:0] cnt_data;
  logic             evt_pulse;
  logic             level_q;
  logic             overflow;

  toggle_event_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tgl_in    (tgl_in),
    .ovf_clr   (ovf_clr),
    .cnt_ready (cnt_ready),
    .cnt_valid (cnt_valid),
    .cnt_data  (cnt_data),
    .evt_pulse (evt_pulse),
    .level_q   (level_q),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: histories of the sampled input and decoded level,
  // plus the count bookkeeping of the output slot.
  bit hist[$];
  bit lev[$];
  bit flv_m;
  int acc_m, data_m;
  bit valid_m, ovf_m, evt_m;
  int warm;
  int events_total, beats_total;
  bit sat_seen;

  task automatic model_reset();
    hist.delete();
    lev.delete();
    for (int i = 0; i < 8; i++) hist.push_back(tgl_in);
    for (int i = 0; i < 4; i++) lev.push_back(tgl_in);
    flv_m = tgl_in;
    acc_m = 0; data_m = 0; valid_m = 0; ovf_m = 0; evt_m = 0;
    warm = 8;
    events_total = 0; beats_total = 0; sat_seen = 0;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_advance();
    int  pend;
    bit  free, new_ovf, lev_now;
    pend    = (acc_m == MAXV) ? MAXV : acc_m + int'(evt_m);
    free    = !valid_m || cnt_ready;
    new_ovf = ovf_m && !ovf_clr;
    if (acc_m == MAXV && evt_m) sat_seen = 1;
    if (free) begin
      if (pend != 0) begin data_m = pend; valid_m = 1; end
      else valid_m = 0;
      acc_m = 0;
    end else begin
      if (acc_m == MAXV && evt_m) new_ovf = 1;
      acc_m = pend;
    end
    ovf_m = new_ovf;

    hist.push_front(tgl_in);
    void'(hist.pop_back());
`ifdef TGL_DEC_GLITCH_FILTER_EN
    if (hist[SYNC_STAGES] == hist[SYNC_STAGES-1]) flv_m = hist[SYNC_STAGES];
    lev_now = flv_m;
`else
    lev_now = hist[SYNC_STAGES-1];
`endif
    evt_m = (lev[0] != lev[1]);
    lev.push_front(lev_now);
    void'(lev.pop_back());
    events_total += int'(evt_m);
    if (warm > 0) warm--;
  endtask

  task automatic compare();
    check("cnt_valid", cnt_valid, valid_m);
    if (valid_m) check("cnt_data", cnt_data, data_m);
    check("evt_pulse", evt_pulse, evt_m);
    check("overflow", overflow, ovf_m);
    if (warm == 0) check("level_q", level_q, lev[0]);
  endtask

  // Called at a negedge: apply inputs, run one edge, check at next negedge.
  task automatic step(input bit t, input bit rdy, input bit clr);
    tgl_in = t; cnt_ready = rdy; ovf_clr = clr;
    if (cnt_valid && rdy) beats_total += int'(cnt_data);
    model_advance();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(tgl_in, rdy, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_valid", cnt_valid, 0);
    check("rst_data", cnt_data, 0);
    check("rst_evt", evt_pulse, 0);
    check("rst_level", level_q, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  int first_idx, npulse;

  initial begin
    // Power-on reset
    @(negedge clk);
    do_reset();
    idle(8, 1'b1);

    // Single toggle with the consumer ready
    first_idx = -1; npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (evt_pulse) begin
        npulse++;
        if (first_idx < 0) first_idx = i;
      end
    end
    check("single_lat", first_idx, LAT);
    check("single_cnt", npulse, 1);

    // Backpressure: four toggles two cycles apart, then one ready cycle
    for (int k = 0; k < 4; k++) begin
      step(~tgl_in, 1'b0, 1'b0);
      step(tgl_in, 1'b0, 1'b0);
    end
    idle(6, 1'b0);
    check("bp_beat1", cnt_data, 1);
    step(tgl_in, 1'b1, 1'b0);
    check("bp_beat2", cnt_data, 3);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Saturation with backpressure, then overflow clear behaviour
    step(~tgl_in, 1'b0, 1'b0);
    idle(6, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step(~tgl_in, 1'b0, 1'b0);
      step(tgl_in, 1'b0, 1'b0);
    end
    idle(6, 1'b0);
    check("sat_ovf", overflow, 1);
    step(tgl_in, 1'b0, 1'b1);
    check("ovf_clr", overflow, 0);
    step(~tgl_in, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !evt_m; i++) step(tgl_in, 1'b0, 1'b0);
    step(tgl_in, 1'b0, 1'b1);
    check("ovf_set_wins", overflow, 1);
    idle(4, 1'b1);

    // Reset in the middle of accumulation
    for (int k = 0; k < 5; k++) begin
      step(~tgl_in, 1'b0, 1'b0);
      step(tgl_in, 1'b0, 1'b0);
    end
    idle(4, 1'b0);
    do_reset();
    idle(8, 1'b0);
    step(~tgl_in, 1'b0, 1'b0);
    idle(6, 1'b0);
    check("post_rst_valid", cnt_valid, 1);
    check("post_rst_data", cnt_data, 1);

    // Handshake and event every cycle: nothing lost or double counted
    for (int k = 0; k < 12; k++) step(~tgl_in, 1'b1, 1'b0);
    idle(8, 1'b1);
    check("conserve_b2b", beats_total, events_total);

    // One-cycle glitch on the toggle line
    npulse = 0;
    step(~tgl_in, 1'b1, 1'b0);
    step(~tgl_in, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(tgl_in, 1'b1, 1'b0);
      npulse += int'(evt_pulse);
    end
    check("glitch_evts", npulse, GLITCH_EVTS);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(2) == 0) ? ~tgl_in : tgl_in,
           1'($urandom_range(3) != 0),
           1'($urandom_range(15) == 0));
    end
    idle(12, 1'b1);
    if (!sat_seen) check("conserve_rand", beats_total, events_total);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
